encrypt: RTL and testbench
==========================

Name: encrypt

Overview:
- Iterative PRESENT-80 block-cipher encryption core: 64-bit block, 80-bit key, 31 rounds, one round per clock.
- Free-running. It captures plaintext/orig_key, encrypts, and pulses Done for one cycle with ciphertext valid. It then automatically recaptures inputs for the next block.
- Sits in the crypto datapath as the encryption engine. It has no input-side handshake.

Parameters:
- BLOCK_W, 64, block width (matches `size`); fixed, not overridable.
- KEY_W, 80, key width (matches `key_size`); fixed.
- ROUNDS, 31, number of full PRESENT rounds.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- orig_key  in  80  cipher key; sampled only in LOAD.
- plaintext  in  64  input block; sampled only in LOAD.
- ciphertext  out  64  registered result; holds its value until the next completed block.
- Done  out  1  registered one-cycle pulse; ciphertext is valid while Done=1.

Behaviour:
- Reset (Reset=0, async):
  - FSM goes to LOAD, round counter = 1.
  - ciphertext = 0, Done = 0.
  - state and key registers = 0.
- FSM states and transitions:
  - LOAD: at the next edge, state <= plaintext, keyreg <= orig_key, counter <= 1, go to RUN.
  - RUN: each edge performs one round using round counter i (1..31):
    - state <= P(S(state ^ keyreg[79:16])).
    - keyreg <= update(keyreg, i).
    - counter <= i+1.
    - After the edge that processes i=31, go to FINAL.
  - FINAL: at the next edge, ciphertext <= state ^ keyreg[79:16] (K32), Done <= 1, go to DONE.
  - DONE: Done is high for exactly this one cycle. At the next edge, Done <= 0 and go to LOAD.
- Timing:
  - Inputs are captured on the edge after leaving DONE, never on the edge that exits DONE. This lets the environment change inputs just after that edge.
  - Latency is 32 edges from the capture edge to Done=1.
  - Throughput is one block per 34 cycles.
- S-box, 4-bit, hex 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2. It is applied to all 16 nibbles of the state.
- pLayer: bit j moves to bit (16*j) mod 63 for j=0..62; bit 63 stays in place.
- Key update, in order:
  - Rotate keyreg left by 61.
  - bits[79:76] <= S(bits[79:76]).
  - bits[19:15] ^= i[4:0].
- Inputs changing during RUN/FINAL/DONE have no effect.
- Reset asserted mid-encryption aborts immediately and returns to the reset values.
- The first Done after reset occurs 33 cycles after the reset deassertion edge.

Decomposition:
- Shared package present_pkg holds:
  - constants BLOCK_W, KEY_W, ROUNDS.
  - FSM state enum {LOAD, RUN, FINAL, DONE}.
  - functions sbox4, s_layer, p_layer, key_update.
- One sub-module, present_round: combinational. Takes state, keyreg and counter; outputs next state and next key.
- encrypt instantiates present_round and holds the FSM, counter and registers.

Test Plan:
- Hold Reset=0 for 2 cycles -> Done=0, ciphertext=0; Done first rises 33 cycles after release.
- plaintext=0000000000000000, key=00000000000000000000 -> ciphertext=5579C1387B228445 with a one-cycle Done pulse.
- plaintext=0000000000000000, key=FFFFFFFFFFFFFFFFFFFF -> ciphertext=E72C46C0F5945049.
- plaintext=FFFFFFFFFFFFFFFF, key=00000000000000000000 -> ciphertext=A112FFC72F68417B.
- plaintext=FFFFFFFFFFFFFFFF, key=FFFFFFFFFFFFFFFFFFFF -> ciphertext=3333DCD3213210D2.
- Back-to-back vectors: change inputs 1 ns after each Done-exit edge -> every vector produces exactly one Done pulse with the correct ciphertext. Also toggle inputs during RUN (no effect), then assert Reset mid-RUN -> outputs return to 0 immediately and the next result is correct.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, FSM states and the round primitives.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int ROUNDS  = 31;
  localparam int CNT_W   = 6;

  // Counter value of the last full round; the FSM leaves RUN after it.
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int n = 0; n < BLOCK_W / 4; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit j goes to (16*j) mod 63; bit 63 is a fixed point.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int j = 0; j < BLOCK_W - 1; j++) begin
      y[(16 * j) % 63] = x[j];
    end
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

  // Rotate left by 61, substitute the top nibble, then mix in the round counter.
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       rc);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/present_round.sv
// One combinational PRESENT round: add round key, S-layer, pLayer, key schedule step.
module present_round
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_state,
  input  logic [KEY_W-1:0]   i_key,
  input  logic [4:0]         i_round,
  output logic [BLOCK_W-1:0] o_state,
  output logic [KEY_W-1:0]   o_key
);

  logic [BLOCK_W-1:0] w_mixed;

  assign w_mixed = i_state ^ i_key[KEY_W-1:KEY_W-BLOCK_W];

  // Round transform on data and key in parallel.
  always_comb begin
    o_state = p_layer(s_layer(w_mixed));
    o_key   = key_update(i_key, i_round);
  end

endmodule

// File: rtl/encrypt.sv
// Iterative PRESENT-80 encryption engine, one round per clock, free-running.
//
// state | meaning
// LOAD  | capture plaintext and key, counter back to 1
// RUN   | one round per edge for counter 1..31
// FINAL | apply the last round key, publish ciphertext
// DONE  | Done high for this single cycle, then recapture
module encrypt
  import present_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic [KEY_W-1:0]   orig_key,
  input  logic [BLOCK_W-1:0] plaintext,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               Done
);

  state_t             r_fsm;
  state_t             w_fsm_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [BLOCK_W-1:0] r_data;
  logic [KEY_W-1:0]   r_key;
  logic [BLOCK_W-1:0] w_data_nxt;
  logic [KEY_W-1:0]   w_key_nxt;

  present_round u_round (
    .i_state (r_data),
    .i_key   (r_key),
    .i_round (r_cnt[4:0]),
    .o_state (w_data_nxt),
    .o_key   (w_key_nxt)
  );

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_fsm <= LOAD;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state logic; RUN exits after the edge that processes the last round.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      LOAD:    w_fsm_nxt = RUN;
      RUN:     if (r_cnt == LAST_ROUND) w_fsm_nxt = FINAL;
      FINAL:   w_fsm_nxt = DONE;
      DONE:    w_fsm_nxt = LOAD;
      default: w_fsm_nxt = LOAD;
    endcase
  end

  // Datapath, round counter and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt      <= CNT_W'(1);
      r_data     <= '0;
      r_key      <= '0;
      ciphertext <= '0;
      Done       <= 1'b0;
    end else begin
      case (r_fsm)
        LOAD: begin
          r_data <= plaintext;
          r_key  <= orig_key;
          r_cnt  <= CNT_W'(1);
        end
        RUN: begin
          r_data <= w_data_nxt;
          r_key  <= w_key_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        FINAL: begin
          ciphertext <= r_data ^ r_key[KEY_W-1:KEY_W-BLOCK_W];
          Done       <= 1'b1;
        end
        DONE: begin
          Done <= 1'b0;
        end
        default: begin
          Done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt.sv
// Directed bench for encrypt: published PRESENT-80 vectors through a scoreboard queue.
module tb_encrypt;

  logic        Clock;
  logic        Reset;
  logic [79:0] orig_key;
  logic [63:0] plaintext;
  logic [63:0] ciphertext;
  logic        Done;

  int n_cmp;
  int n_bad;

  logic [63:0] pt_v  [4];
  logic [79:0] key_v [4];
  logic [63:0] ct_v  [4];
  logic [63:0] exp_q [$];

  encrypt dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .orig_key   (orig_key),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .Done       (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input int idx);
    plaintext = pt_v[idx];
    orig_key  = key_v[idx];
    exp_q.push_back(ct_v[idx]);
  endtask

  // Wait for Done, checking edge count, ciphertext, pulse width and hold.
  task automatic wait_done(input string tag, input int exp_edges);
    int          n;
    bit          got;
    logic [63:0] e;
    n   = 0;
    got = 0;
    while (n < 200 && !got) begin
      @(posedge Clock);
      #1;
      n++;
      if (Done === 1'b1) got = 1;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_edges));
    if (got) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_ct"}, ciphertext, e);
        @(posedge Clock);
        #1;
        check({tag, "_pulse"}, 64'(Done), 64'd0);
        check({tag, "_hold"}, ciphertext, e);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pt_v[0] = 64'h0000000000000000; key_v[0] = 80'h00000000000000000000; ct_v[0] = 64'h5579C1387B228445;
    pt_v[1] = 64'h0000000000000000; key_v[1] = 80'hFFFFFFFFFFFFFFFFFFFF; ct_v[1] = 64'hE72C46C0F5945049;
    pt_v[2] = 64'hFFFFFFFFFFFFFFFF; key_v[2] = 80'h00000000000000000000; ct_v[2] = 64'hA112FFC72F68417B;
    pt_v[3] = 64'hFFFFFFFFFFFFFFFF; key_v[3] = 80'hFFFFFFFFFFFFFFFFFFFF; ct_v[3] = 64'h3333DCD3213210D2;

    // Reset hold.
    Reset = 1'b0;
    apply(0);
    repeat (2) @(posedge Clock);
    #1;
    check("rst_done", 64'(Done), 64'd0);
    check("rst_ct", ciphertext, 64'd0);

    // First block after reset: Done on the 33rd edge after release.
    @(negedge Clock);
    Reset = 1'b1;
    wait_done("v0", 33);

    // Back-to-back vectors, inputs changed 1 ns after each DONE-exit edge.
    apply(1);
    wait_done("v1", 33);
    apply(2);
    wait_done("v2", 33);
    apply(3);
    wait_done("v3", 33);
    apply(0);
    wait_done("v0_again", 33);

    // Inputs toggled during RUN are ignored.
    apply(1);
    repeat (6) @(posedge Clock);
    #1;
    plaintext = {$urandom, $urandom};
    orig_key  = {16'($urandom), $urandom, $urandom};
    repeat (10) @(posedge Clock);
    #1;
    plaintext = ~plaintext;
    orig_key  = ~orig_key;
    wait_done("toggle_run", 17);

    // Reset mid-RUN aborts the block and clears outputs at once.
    apply(2);
    repeat (11) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check("midrst_done", 64'(Done), 64'd0);
    check("midrst_ct", ciphertext, 64'd0);
    void'(exp_q.pop_back());
    apply(3);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    wait_done("post_rst", 33);

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
